bus_unit: RTL and testbench

- Responder side of the sequencer's memory-request outputs: consumes addr_sel / inc_pc / fetch_cycle / mem_to_r8, owns the PC, and runs the external memory read.
- Returns fetched bytes as an opcode latch (IR) for the decoder, or as an r8 write-back for the register file.
- Frames each request as one M-cycle of T_PER_M clocks, with memory wait-state support, and pulses m_done so the sequencer advances.

---
 rtl/bus_unit.sv | 138 +++++++++++++
 tb/tb_bus_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_unit.sv
// bus_unit -- memory-request responder for the sequencer.
//
// Owns the program counter and runs one external memory read per M-cycle.
// Each M-cycle lasts T_PER_M clocks (longer when memory inserts wait states).
// The request inputs are sampled at phase 0 and held for the whole M-cycle.
// The fetched byte is returned as an opcode (ir/ir_valid) or as a register
// write-back (r8_wdata/r8_we). m_done pulses once per completed M-cycle.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   addr_sel              address source for this M-cycle (PC or NONE)
//   inc_pc                increment pc when the M-cycle completes
//   fetch_cycle           capture the read byte into ir
//   mem_to_r8             capture the read byte into r8_wdata
//   mem_addr, mem_rd      external memory address and read strobe
//   mem_rdata, mem_ready  external read data and data-valid / no-wait
//   pc                    current program counter
//   ir, ir_valid          latched opcode and its one-clock update pulse
//   r8_wdata, r8_we       register write-back byte and one-clock strobe
//   m_done                one-clock pulse at M-cycle completion
//   req_err               sticky: capture requested without an address source

package bus_unit_pkg;
  typedef enum logic {
    ADDR_NONE = 1'b0,
    ADDR_PC   = 1'b1
  } addr_sel_t;
endpackage

module bus_unit
  import bus_unit_pkg::*;
#(
  parameter int          T_PER_M  = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  addr_sel_t   addr_sel,
  input  logic        inc_pc,
  input  logic        fetch_cycle,
  input  logic        mem_to_r8,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready,
  output logic [15:0] pc,
  output logic [7:0]  ir,
  output logic        ir_valid,
  output logic [7:0]  r8_wdata,
  output logic        r8_we,
  output logic        m_done,
  output logic        req_err
);

  localparam int            PH_W    = (T_PER_M > 2) ? $clog2(T_PER_M) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(T_PER_M - 1);
  localparam logic [PH_W-1:0] PH_ONE  = PH_W'(1);

  logic [PH_W-1:0] ph;

  // Request latched at phase 0 and held for the rest of the M-cycle.
  addr_sel_t lat_sel;
  logic      lat_inc;
  logic      lat_fetch;
  logic      lat_r8;

  logic lat_pc;
  logic complete;

  assign lat_pc = (lat_sel == ADDR_PC);

  // A NONE cycle never waits on memory; a read waits for mem_ready.
  assign complete = (ph == PH_LAST) && (!lat_pc || mem_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph        <= '0;
      lat_sel   <= ADDR_NONE;
      lat_inc   <= 1'b0;
      lat_fetch <= 1'b0;
      lat_r8    <= 1'b0;
      pc        <= RESET_PC;
      ir        <= 8'h00;
      r8_wdata  <= 8'h00;
      mem_addr  <= 16'h0000;
      mem_rd    <= 1'b0;
      ir_valid  <= 1'b0;
      r8_we     <= 1'b0;
      m_done    <= 1'b0;
      req_err   <= 1'b0;
    end else begin
      ir_valid <= 1'b0;
      r8_we    <= 1'b0;
      m_done   <= 1'b0;

      if (ph == '0) begin
        // Sample the request; the read strobe covers phases 1..T_PER_M-1.
        lat_sel   <= addr_sel;
        lat_inc   <= inc_pc;
        lat_fetch <= fetch_cycle;
        lat_r8    <= mem_to_r8;
        ph        <= PH_ONE;
        if (addr_sel == ADDR_PC) begin
          mem_rd   <= 1'b1;
          mem_addr <= pc;
        end else begin
          mem_rd <= 1'b0;
        end
      end else if (ph == PH_LAST) begin
        // Last phase: hold here (address and strobe stable) until complete.
        if (complete) begin
          ph     <= '0;
          mem_rd <= 1'b0;
          m_done <= 1'b1;
          if (lat_pc) begin
            if (lat_fetch) begin
              ir       <= mem_rdata;
              ir_valid <= 1'b1;
            end
            if (lat_r8) begin
              r8_wdata <= mem_rdata;
              r8_we    <= 1'b1;
            end
          end else if (lat_fetch || lat_r8) begin
            req_err <= 1'b1;
          end
          // mem_addr already holds the pre-increment pc for this cycle.
          if (lat_inc) begin
            pc <= pc + 16'd1;
          end
        end
      end else begin
        ph <= ph + PH_ONE;
      end
    end
  end

endmodule

// File: tb/tb_bus_unit.sv
module tb_bus_unit;
  import bus_unit_pkg::*;

  localparam int T_PER_M = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  addr_sel_t   addr_sel;
  logic        inc_pc;
  logic        fetch_cycle;
  logic        mem_to_r8;
  logic [7:0]  mem_rdata;
  logic        mem_ready;

  // Instance A: RESET_PC = 0000
  logic [15:0] a_mem_addr, a_pc;
  logic        a_mem_rd, a_ir_valid, a_r8_we, a_m_done, a_req_err;
  logic [7:0]  a_ir, a_r8_wdata;

  // Instance B: RESET_PC = FFFF, same stimulus (exercises pc wrap)
  logic [15:0] b_mem_addr, b_pc;
  logic        b_mem_rd, b_ir_valid, b_r8_we, b_m_done, b_req_err;
  logic [7:0]  b_ir, b_r8_wdata;

  bus_unit #(.T_PER_M(T_PER_M), .RESET_PC(16'h0000)) dut_a (
    .clk(clk), .rst_n(rst_n), .addr_sel(addr_sel), .inc_pc(inc_pc),
    .fetch_cycle(fetch_cycle), .mem_to_r8(mem_to_r8),
    .mem_addr(a_mem_addr), .mem_rd(a_mem_rd), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .pc(a_pc), .ir(a_ir), .ir_valid(a_ir_valid),
    .r8_wdata(a_r8_wdata), .r8_we(a_r8_we), .m_done(a_m_done),
    .req_err(a_req_err)
  );

  bus_unit #(.T_PER_M(T_PER_M), .RESET_PC(16'hFFFF)) dut_b (
    .clk(clk), .rst_n(rst_n), .addr_sel(addr_sel), .inc_pc(inc_pc),
    .fetch_cycle(fetch_cycle), .mem_to_r8(mem_to_r8),
    .mem_addr(b_mem_addr), .mem_rd(b_mem_rd), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .pc(b_pc), .ir(b_ir), .ir_valid(b_ir_valid),
    .r8_wdata(b_r8_wdata), .r8_we(b_r8_we), .m_done(b_m_done),
    .req_err(b_req_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ir_v;
    logic        r8_v;
    logic [7:0]  ir;
    logic [7:0]  r8;
    logic [15:0] pc_a;
    logic [15:0] pc_b;
    logic        err;
    int          lat;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [15:0] m_pc_a, m_pc_b;
  logic [7:0]  m_ir, m_r8;
  logic        m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one M-cycle request; push the expected outcome, then run until
  // m_done and compare against the popped scoreboard entry.
  task automatic do_req(input addr_sel_t sel, input logic inc, input logic f,
                        input logic r, input logic [7:0] data, input int waits);
    exp_t        e;
    logic        cap;
    logic [15:0] addr_a, addr_b;
    int          n;

    cap    = (sel == ADDR_PC);
    addr_a = m_pc_a;
    addr_b = m_pc_b;
    if (cap && f) m_ir = data;
    if (cap && r) m_r8 = data;
    if (!cap && (f || r)) m_err = 1'b1;
    if (inc) begin
      m_pc_a = m_pc_a + 16'd1;
      m_pc_b = m_pc_b + 16'd1;
    end
    e.ir_v = cap && f;
    e.r8_v = cap && r;
    e.ir   = m_ir;
    e.r8   = m_r8;
    e.pc_a = m_pc_a;
    e.pc_b = m_pc_b;
    e.err  = m_err;
    e.lat  = T_PER_M + waits;
    exp_q.push_back(e);

    addr_sel    = sel;
    inc_pc      = inc;
    fetch_cycle = f;
    mem_to_r8   = r;
    mem_ready   = (waits == 0);
    mem_rdata   = (waits == 0) ? data : ~data;
    tick();
    n = 1;
    // Mid-cycle input changes must be ignored.
    addr_sel    = ADDR_NONE;
    inc_pc      = 1'b0;
    fetch_cycle = 1'b0;
    mem_to_r8   = 1'b0;

    while (!a_m_done && n < T_PER_M + waits + 8) begin
      chk("mem_rd_a", a_mem_rd, cap);
      chk("mem_rd_b", b_mem_rd, cap);
      if (cap) begin
        chk("mem_addr_a", a_mem_addr, addr_a);
        chk("mem_addr_b", b_mem_addr, addr_b);
      end
      chk("ir_valid_idle", a_ir_valid, 1'b0);
      chk("r8_we_idle", a_r8_we, 1'b0);
      if (n >= T_PER_M - 1 + waits) begin
        mem_ready = 1'b1;
        mem_rdata = data;
      end
      tick();
      n++;
    end

    chk("m_done_a", a_m_done, 1'b1);
    chk("m_done_b", b_m_done, 1'b1);
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("latency", n, e.lat);
      chk("ir_valid_a", a_ir_valid, e.ir_v);
      chk("r8_we_a", a_r8_we, e.r8_v);
      chk("ir_a", a_ir, e.ir);
      chk("r8_wdata_a", a_r8_wdata, e.r8);
      chk("pc_a", a_pc, e.pc_a);
      chk("req_err_a", a_req_err, e.err);
      chk("ir_b", b_ir, e.ir);
      chk("pc_b", b_pc, e.pc_b);
      chk("req_err_b", b_req_err, e.err);
      chk("mem_rd_done", a_mem_rd, 1'b0);
    end
    mem_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n       = 1'b0;
    addr_sel    = ADDR_NONE;
    inc_pc      = 1'b0;
    fetch_cycle = 1'b0;
    mem_to_r8   = 1'b0;
    mem_rdata   = 8'h00;
    mem_ready   = 1'b1;
    m_pc_a      = 16'h0000;
    m_pc_b      = 16'hFFFF;
    m_ir        = 8'h00;
    m_r8        = 8'h00;
    m_err       = 1'b0;

    tick();
    tick();
    // Reset state
    chk("rst_pc_a", a_pc, 16'h0000);
    chk("rst_pc_b", b_pc, 16'hFFFF);
    chk("rst_ir", a_ir, 8'h00);
    chk("rst_mem_rd", a_mem_rd, 1'b0);
    chk("rst_mem_addr", a_mem_addr, 16'h0000);
    chk("rst_m_done", a_m_done, 1'b0);
    chk("rst_req_err", a_req_err, 1'b0);
    rst_n = 1'b1;

    // Opcode fetch with increment; B wraps FFFF -> 0000
    do_req(ADDR_PC, 1'b1, 1'b1, 1'b0, 8'h3E, 0);
    // Register write-back, back-to-back
    do_req(ADDR_PC, 1'b1, 1'b0, 1'b1, 8'h5A, 0);
    // Three wait states at the last phase
    do_req(ADDR_PC, 1'b1, 1'b1, 1'b0, 8'hC7, 3);
    // Fetch and r8 capture together, no increment
    do_req(ADDR_PC, 1'b0, 1'b1, 1'b1, 8'h81, 0);
    // Capture requested with no address source
    do_req(ADDR_NONE, 1'b1, 1'b1, 1'b0, 8'hEE, 0);
    // Advance pc to 0010 with increment-only cycles (req_err stays sticky)
    for (int i = 0; i < 64 && m_pc_a != 16'h0010; i++) begin
      do_req(ADDR_NONE, 1'b1, 1'b0, 1'b0, 8'h00, 0);
    end
    chk("pc_before_rst", a_pc, 16'h0010);

    // Reset asserted during phase 2 of a read
    addr_sel    = ADDR_PC;
    inc_pc      = 1'b1;
    fetch_cycle = 1'b1;
    mem_to_r8   = 1'b1;
    mem_rdata   = 8'h99;
    mem_ready   = 1'b1;
    tick();
    chk("abort_mem_addr", a_mem_addr, 16'h0010);
    chk("abort_mem_rd", a_mem_rd, 1'b1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("arst_mem_rd", a_mem_rd, 1'b0);
    chk("arst_mem_addr", a_mem_addr, 16'h0000);
    chk("arst_pc_a", a_pc, 16'h0000);
    chk("arst_pc_b", b_pc, 16'hFFFF);
    chk("arst_ir", a_ir, 8'h00);
    chk("arst_r8_wdata", a_r8_wdata, 8'h00);
    chk("arst_req_err", a_req_err, 1'b0);
    chk("arst_m_done", a_m_done, 1'b0);
    m_pc_a = 16'h0000;
    m_pc_b = 16'hFFFF;
    m_ir   = 8'h00;
    m_r8   = 8'h00;
    m_err  = 1'b0;
    exp_q.delete();
    addr_sel    = ADDR_NONE;
    inc_pc      = 1'b0;
    fetch_cycle = 1'b0;
    mem_to_r8   = 1'b0;
    tick();
    chk("arst_hold_pc", a_pc, 16'h0000);
    rst_n = 1'b1;

    // First request after release is sampled on the first clock
    do_req(ADDR_PC, 1'b1, 1'b1, 1'b0, 8'h42, 0);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
